// File: rtl/adder_pkg.sv
// Shared arithmetic package: default operand geometry, pipeline depth
// computation and parameter legality check for the chunked adders.
package adder_pkg;

  // Default operand width and per-stage chunk width for arithmetic blocks.
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  // Number of pipeline stages for a given operand width and chunk width.
  // A zero chunk is illegal anyway; returning 1 keeps elaboration from
  // dividing by zero before the legality check can report the problem.
  function automatic int calc_stages(input int width, input int chunk);
    int stages;
    if (chunk <= 0) begin
      stages = 1;
    end else begin
      stages = width / chunk;
    end
    return stages;
  endfunction

  // True when the width/chunk pair describes a buildable adder: at least
  // two bits wide and an exact whole number of chunks.
  function automatic bit params_legal(input int width, input int chunk);
    bit legal;
    if ((width < 2) || (chunk < 1) || (chunk > width)) begin
      legal = 1'b0;
    end else begin
      legal = ((width % chunk) == 0);
    end
    return legal;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage of the chunked adder: a CHUNK-bit ripple add with
// carry-in, registered sum, carry-out, carry-into-MSB and a valid bit.
// All registers hold while en is low.
module adder_stage
  import adder_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic [CHUNK-1:0] a_in,
  input  logic [CHUNK-1:0] b_in,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum_r,
  output logic             carry_r,
  output logic             cmsb_r,
  output logic             valid_r
);

  logic [CHUNK:0] total_s;
  logic           cmsb_s;

  // Chunk addition; the carry into the top bit is recovered from the sum
  // bit, since sum = a ^ b ^ carry_into_bit at every position.
  always_comb begin
    total_s = {1'b0, a_in} + {1'b0, b_in} + {{CHUNK{1'b0}}, carry_in};
    cmsb_s  = total_s[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1];
  end

  // Stage register: loads on advance, holds during a stall, clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r   <= '0;
      carry_r <= 1'b0;
      cmsb_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (en) begin
      sum_r   <= total_s[CHUNK-1:0];
      carry_r <= total_s[CHUNK];
      cmsb_r  <= cmsb_s;
      valid_r <= valid_in;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with carry-in, carry-out and signed overflow.
// The carry chain is cut into CHUNK-bit stages; upper operand chunks are
// delayed (skew) to meet their stage, lower sum chunks are delayed
// (de-skew) to line up at the output. A single global enable stalls the
// whole pipeline, so bubbles never compress.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2 and a whole multiple of CHUNK");
  end

  logic                en_s;
  logic [CHUNK-1:0]    a_chunk_s   [STAGES];
  logic [CHUNK-1:0]    b_chunk_s   [STAGES];
  logic [CHUNK-1:0]    stage_sum_s [STAGES];
  logic [STAGES-1:0]   carry_s;
  logic [STAGES-1:0]   cmsb_s;
  logic [STAGES-1:0]   valid_s;
  logic                unused_cmsb_s;

  // Global advance: move whenever the output slot is empty or being drained.
  assign en_s     = !valid_s[STAGES-1] || out_ready;
  assign in_ready = en_s;

  // Only the last stage's carry-into-MSB matters (for overflow).
  assign unused_cmsb_s = ^cmsb_s;

  // Chunk 0 goes straight into stage 0.
  assign a_chunk_s[0] = a[CHUNK-1:0];
  assign b_chunk_s[0] = b[CHUNK-1:0];

  // Skew: chunk j waits j cycles so it meets the carry from chunk j-1.
  for (genvar j = 1; j < STAGES; j++) begin : g_skew
    logic [CHUNK-1:0] a_dly_r [j];
    logic [CHUNK-1:0] b_dly_r [j];

    // Operand chunk delay line, advancing with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < j; i++) begin
          a_dly_r[i] <= '0;
          b_dly_r[i] <= '0;
        end
      end else if (en_s) begin
        a_dly_r[0] <= a[j*CHUNK +: CHUNK];
        b_dly_r[0] <= b[j*CHUNK +: CHUNK];
        for (int i = 1; i < j; i++) begin
          a_dly_r[i] <= a_dly_r[i-1];
          b_dly_r[i] <= b_dly_r[i-1];
        end
      end
    end

    assign a_chunk_s[j] = a_dly_r[j-1];
    assign b_chunk_s[j] = b_dly_r[j-1];
  end

  // Carry-chain stages; stage k takes the registered carry of stage k-1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic carry_in_s;
    logic valid_in_s;

    if (k == 0) begin : g_first
      assign carry_in_s = cin;
      assign valid_in_s = in_valid;
    end else begin : g_next
      assign carry_in_s = carry_s[k-1];
      assign valid_in_s = valid_s[k-1];
    end

    adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en_s),
      .valid_in (valid_in_s),
      .a_in     (a_chunk_s[k]),
      .b_in     (b_chunk_s[k]),
      .carry_in (carry_in_s),
      .sum_r    (stage_sum_s[k]),
      .carry_r  (carry_s[k]),
      .cmsb_r   (cmsb_s[k]),
      .valid_r  (valid_s[k])
    );
  end

  // De-skew: sum chunk j is ready STAGES-1-j cycles before the top chunk.
  for (genvar j = 0; j < STAGES - 1; j++) begin : g_deskew
    localparam int DEPTH = STAGES - 1 - j;
    logic [CHUNK-1:0] s_dly_r [DEPTH];

    // Sum chunk delay line, advancing with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          s_dly_r[i] <= '0;
        end
      end else if (en_s) begin
        s_dly_r[0] <= stage_sum_s[j];
        for (int i = 1; i < DEPTH; i++) begin
          s_dly_r[i] <= s_dly_r[i-1];
        end
      end
    end

    assign sum[j*CHUNK +: CHUNK] = s_dly_r[DEPTH-1];
  end

  assign sum[WIDTH-1 -: CHUNK] = stage_sum_s[STAGES-1];
  assign out_valid             = valid_s[STAGES-1];
  assign carry                 = carry_s[STAGES-1];
  assign overflow              = carry_s[STAGES-1] ^ cmsb_s[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder. Two instances run side by side:
// WIDTH=16/CHUNK=4 (four stages) and WIDTH=8/CHUNK=8 (one stage). A
// reference model predicts acceptance, occupancy and results from plain
// integer arithmetic and an in-order result queue.
module tb_pipelined_adder;

  localparam int S16 = 4;
  localparam int S8  = 1;

  logic        clk;
  logic        rst_n;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, carry16, ovf16;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, carry8, ovf8;

  // Staged stimulus applied at the next falling edge.
  logic        nxt_iv16, nxt_c16, nxt_or16;
  logic [15:0] nxt_a16, nxt_b16;
  logic        nxt_iv8, nxt_c8, nxt_or8;
  logic [7:0]  nxt_a8, nxt_b8;

  // Model state: expected results in order, and pipeline occupancy.
  logic [17:0] q16[$];
  logic [9:0]  q8[$];
  logic        occ16 [S16];
  logic        occ8  [S8];
  int          acc16, acc8;

  int checks;
  int errors;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .carry(carry16), .overflow(ovf16)
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .carry(carry8), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {overflow, carry, sum} of x + y + c for 16-bit operands.
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [31:0] t;
    logic [15:0] s;
    logic        v;
    t = 32'(x) + 32'(y) + 32'(c);
    s = t[15:0];
    v = (x[15] == y[15]) && (s[15] != x[15]);
    return {v, t[16], s};
  endfunction

  // {overflow, carry, sum} of x + y + c for 8-bit operands.
  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [31:0] t;
    logic [7:0]  s;
    logic        v;
    t = 32'(x) + 32'(y) + 32'(c);
    s = t[7:0];
    v = (x[7] == y[7]) && (s[7] != x[7]);
    return {v, t[8], s};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S16; i++) occ16[i] = 1'b0;
    for (int i = 0; i < S8; i++) occ8[i] = 1'b0;
    q16.delete();
    q8.delete();
  endtask

  // One clock cycle: apply staged inputs at the falling edge, check the
  // outputs against the model, then advance the model as the next rising
  // edge will.
  task automatic tick();
    logic e_ov, e_en, e_acc;
    @(negedge clk);
    in_valid16 = nxt_iv16; a16 = nxt_a16; b16 = nxt_b16; cin16 = nxt_c16; out_ready16 = nxt_or16;
    in_valid8  = nxt_iv8;  a8  = nxt_a8;  b8  = nxt_b8;  cin8  = nxt_c8;  out_ready8  = nxt_or8;
    #1;

    e_ov = occ16[S16-1];
    e_en = !e_ov || nxt_or16;
    check_value("in_ready16", 32'(in_ready16), 32'(e_en));
    check_value("out_valid16", 32'(out_valid16), 32'(e_ov));
    if (e_ov && (q16.size() > 0)) begin
      check_value("sum16", 32'(sum16), 32'(q16[0][15:0]));
      check_value("carry16", 32'(carry16), 32'(q16[0][16]));
      check_value("overflow16", 32'(ovf16), 32'(q16[0][17]));
      if (nxt_or16) void'(q16.pop_front());
    end
    e_acc = nxt_iv16 && e_en;
    if (e_acc) begin
      q16.push_back(ref16(nxt_a16, nxt_b16, nxt_c16));
      acc16++;
    end
    if (e_en) begin
      for (int i = S16 - 1; i > 0; i--) occ16[i] = occ16[i-1];
      occ16[0] = e_acc;
    end

    e_ov = occ8[S8-1];
    e_en = !e_ov || nxt_or8;
    check_value("in_ready8", 32'(in_ready8), 32'(e_en));
    check_value("out_valid8", 32'(out_valid8), 32'(e_ov));
    if (e_ov && (q8.size() > 0)) begin
      check_value("sum8", 32'(sum8), 32'(q8[0][7:0]));
      check_value("carry8", 32'(carry8), 32'(q8[0][8]));
      check_value("overflow8", 32'(ovf8), 32'(q8[0][9]));
      if (nxt_or8) void'(q8.pop_front());
    end
    e_acc = nxt_iv8 && e_en;
    if (e_acc) begin
      q8.push_back(ref8(nxt_a8, nxt_b8, nxt_c8));
      acc8++;
    end
    if (e_en) begin
      for (int i = S8 - 1; i > 0; i--) occ8[i] = occ8[i-1];
      occ8[0] = e_acc;
    end
  endtask

  // Single directed operation on the 16-bit instance with latency and
  // result checks against the values written in the test plan.
  task automatic single_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic [15:0] es, input logic ec, input logic eo);
    int edges;
    nxt_iv16 = 1'b1; nxt_a16 = av; nxt_b16 = bv; nxt_c16 = cv; nxt_or16 = 1'b1;
    tick();
    nxt_iv16 = 1'b0;
    edges = 0;
    do begin
      tick();
      edges++;
    end while ((out_valid16 !== 1'b1) && (edges < 20));
    check_value({tag, "_latency"}, 32'(edges), 32'(S16));
    check_value({tag, "_sum"}, 32'(sum16), 32'(es));
    check_value({tag, "_carry"}, 32'(carry16), 32'(ec));
    check_value({tag, "_overflow"}, 32'(ovf16), 32'(eo));
    tick();
    check_value({tag, "_valid_drop"}, 32'(out_valid16), 32'd0);
  endtask

  initial begin
    int cyc;
    checks = 0; errors = 0; acc16 = 0; acc8 = 0;
    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid8  = 1'b0; a8  = 8'h00;    b8  = 8'h00;    cin8  = 1'b0; out_ready8  = 1'b1;
    nxt_iv16 = 1'b0; nxt_a16 = 16'h0000; nxt_b16 = 16'h0000; nxt_c16 = 1'b0; nxt_or16 = 1'b1;
    nxt_iv8  = 1'b0; nxt_a8  = 8'h00;    nxt_b8  = 8'h00;    nxt_c8  = 1'b0; nxt_or8  = 1'b1;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_value("rst_out_valid16", 32'(out_valid16), 32'd0);
    check_value("rst_sum16", 32'(sum16), 32'd0);
    check_value("rst_carry16", 32'(carry16), 32'd0);
    check_value("rst_overflow16", 32'(ovf16), 32'd0);
    check_value("rst_in_ready16", 32'(in_ready16), 32'd1);
    check_value("rst_out_valid8", 32'(out_valid8), 32'd0);
    rst_n = 1'b1;

    // Directed operations.
    single_op("carry_into_chunk1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    single_op("full_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    single_op("pos_overflow", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_op("neg_overflow", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Eight back-to-back operands, then a three-cycle output stall.
    nxt_or16 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nxt_iv16 = 1'b1; nxt_a16 = 16'($urandom()); nxt_b16 = 16'($urandom());
      nxt_c16 = 1'($urandom_range(0, 1));
      tick();
    end
    nxt_or16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt_a16 = 16'($urandom()); nxt_b16 = 16'($urandom());
      tick();
      check_value("stall_in_ready", 32'(in_ready16), 32'd0);
      check_value("stall_out_valid", 32'(out_valid16), 32'd1);
    end
    nxt_iv16 = 1'b0; nxt_or16 = 1'b1;
    for (int i = 0; (i < 20) && (q16.size() > 0); i++) tick();
    tick();
    check_value("b2b_drained", 32'(out_valid16), 32'd0);

    // Reset with operations in flight.
    for (int i = 0; i < 4; i++) begin
      nxt_iv16 = 1'b1; nxt_a16 = 16'h1000 + 16'(i); nxt_b16 = 16'h0101; nxt_c16 = 1'b1;
      tick();
    end
    nxt_iv16 = 1'b0; nxt_or16 = 1'b0;
    tick();
    check_value("pre_rst_out_valid", 32'(out_valid16), 32'd1);
    rst_n = 1'b0;
    in_valid16 = 1'b0;
    #1;
    check_value("midrst_out_valid", 32'(out_valid16), 32'd0);
    check_value("midrst_sum", 32'(sum16), 32'd0);
    check_value("midrst_carry", 32'(carry16), 32'd0);
    check_value("midrst_overflow", 32'(ovf16), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nxt_or16 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    single_op("after_reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Randomised handshakes on both instances.
    begin
      int base16, base8;
      base16 = acc16; base8 = acc8; cyc = 0;
      while (((acc16 - base16) < 10000 || (acc8 - base8) < 10000) && (cyc < 60000)) begin
        nxt_iv16 = ((acc16 - base16) < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
        nxt_a16 = 16'($urandom()); nxt_b16 = 16'($urandom()); nxt_c16 = 1'($urandom_range(0, 1));
        nxt_or16 = 1'($urandom_range(0, 1));
        nxt_iv8 = ((acc8 - base8) < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
        nxt_a8 = 8'($urandom()); nxt_b8 = 8'($urandom()); nxt_c8 = 1'($urandom_range(0, 1));
        nxt_or8 = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
      check_value("random_budget", 32'(cyc < 60000), 32'd1);
    end
    nxt_iv16 = 1'b0; nxt_or16 = 1'b1; nxt_iv8 = 1'b0; nxt_or8 = 1'b1;
    for (int i = 0; (i < 50) && ((q16.size() > 0) || (q8.size() > 0)); i++) tick();
    tick();
    check_value("random_drained16", 32'(out_valid16), 32'd0);
    check_value("random_drained8", 32'(out_valid8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two-operand adder. It generalises the single-bit half adder to `WIDTH`-bit operands with carry-in, carry-out and signed overflow. The carry chain is split into `CHUNK`-bit stages so one addition is accepted per clock at high frequency. It is the arithmetic building block for the team's datapath blocks (accumulators, address generators) and sits between a valid/ready producer and consumer.

## Interface
Parameters:
- `WIDTH`, default 16: operand and sum width in bits. Must be at least 2.
- `CHUNK`, default 4: bits added per pipeline stage. `WIDTH % CHUNK` must be 0; any other value is an elaboration error.
- Derived `STAGES = WIDTH/CHUNK`: pipeline depth and latency. Not overridable.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operands present.
- `in_ready`, out, 1: block can accept operands this cycle.
- `a`, in, `WIDTH`: operand A.
- `b`, in, `WIDTH`: operand B.
- `cin`, in, 1: carry-in.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer accepts the result.
- `sum`, out, `WIDTH`: (a + b + cin) mod 2^WIDTH.
- `carry`, out, 1: unsigned carry-out of the MSB.
- `overflow`, out, 1: two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- Stage k (0..STAGES-1) adds chunk k of a and b plus the carry registered by stage k-1. Stage 0 uses `cin`.
- Operand chunks above k travel through skew registers. Sum chunks below k travel through de-skew registers.
- Each stage holds a valid bit. There is no other FSM state; the pipeline is a shift register of (valid, partial data).
- Global advance enable: `en = !out_valid || out_ready`. `in_ready = en`, driven combinationally.
- A transfer occurs when `in_valid && in_ready`. Stage 0 then loads and its valid bit becomes 1. If `en` is high and no transfer occurs, stage 0's valid bit becomes 0 (a bubble).
- When `en` = 0, every stage register holds, including data and valid bits. `sum`, `carry` and `overflow` stay stable while `out_valid && !out_ready`.
- Bubbles propagate like data. Data registers may load don't-care values on bubbles, but outputs are meaningful only when `out_valid` = 1.
- `overflow` comes from the last stage: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Reset (asynchronous, any time, including mid-flight):
  - all valid bits clear to 0, so `out_valid` = 0;
  - `sum`, `carry`, `overflow` and all data registers reset to 0;
  - in-flight operations are discarded.
- Deassertion of reset is synchronous to `clk`. The first transfer is possible on the first edge after release.

## Timing
- Latency: an operation accepted at rising edge n drives `out_valid` = 1 with its result after edge n+STAGES-1. It is visible in the cycle following that edge, i.e. STAGES edges after acceptance counting the accept edge.
- Throughput: one result per clock while `out_ready` = 1.
- Simultaneous events:
  - a result leaving and a new operand entering in the same cycle are both accepted;
  - bubbles do not compress. Stalls are global, with no partial-advance skid.
- `in_ready` depends combinationally on `out_ready`. Integrators must not close a loop from `in_ready` back to `out_ready`.
- Critical path: one `CHUNK`-bit ripple plus one carry register per stage.

## Structure
- Shared package `adder_pkg`:
  - `STAGES` computation function;
  - parameter-legality check;
  - default `WIDTH` and `CHUNK` constants, reused by later arithmetic blocks.
- Sub-module `adder_stage`: one `CHUNK`-bit registered add with carry-in, carry-out, carry-into-MSB output, and hold enable. It is instantiated STAGES times by a generate loop.
- Skew and de-skew registers live in the top level.

## Test plan
All scenarios use `WIDTH`=16, `CHUNK`=4 (STAGES=4) and `out_ready`=1 unless stated.
- a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, carry=0, overflow=0, `out_valid` rises 4 edges after acceptance.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, carry=1, overflow=0. Checks the full-width carry ripple through all stages.
- a=0x7FFF, b=0x0001 -> sum=0x8000, carry=0, overflow=1; a=0x8000, b=0x8000 -> sum=0x0000, carry=1, overflow=1.
- 8 back-to-back random operands, then `out_ready` held low 3 cycles while `out_valid`=1 -> `in_ready`=0 and outputs stable during the stall. All 8 results emerge in order and match the model, with no loss or duplication.
- Reset asserted with 3 operations in flight -> `out_valid`=0 and sum=0 immediately, before the next edge. No stale result appears after release. A new operation 0x1234+0x1111 then returns 0x2345.
- Randomised `in_valid`/`out_ready` (50%) over 10k operations, also run with `WIDTH`=8, `CHUNK`=8 (STAGES=1) -> scoreboard match, in-order delivery.
